// File: rtl/irq_pkg.sv
// ============================================================================
// Module      : irq_pkg
// Description : Shared types and constants for the N-line interrupt controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package irq_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        IRQ_ACT    = 2'd1,
        EXC_ACT    = 2'd2,
        EXC_IN_IRQ = 2'd3
    } irq_state_e;

    localparam logic [31:0] C_CAUSE_BASE_DEFAULT = 32'h8000_0010;

    // A single-line controller still needs a 1-bit index field.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/irq_prio_encoder.sv
// ============================================================================
// Module      : irq_prio_encoder
// Description : Combinational lowest-index-wins priority encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_prio_encoder
    import irq_pkg::*;
#(
    parameter int N     = 16,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     i_vec,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    always_comb begin
        o_idx   = '0;
        o_valid = |i_vec;
        // Scan downwards so the lowest set bit is the last one written.
        for (int k = N - 1; k >= 0; k--) begin
            if (i_vec[k]) begin
                o_idx = IDX_W'(k);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/irq_prio_controller.sv
// ============================================================================
// Module      : irq_prio_controller
// Description : N-line fixed-priority interrupt controller with one level of
//               exception nesting. Define IRQ_EDGE_DETECT_EN for edge capture.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_prio_controller
    import irq_pkg::*;
#(
    parameter int          N_IRQ      = 16,
    parameter logic [31:0] CAUSE_BASE = C_CAUSE_BASE_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             exception_i,
    input  logic [N_IRQ-1:0] irq_req_i,
    input  logic [N_IRQ-1:0] irq_mask_i,
    input  logic             mie_i,
    input  logic             mret_i,
    output logic             irq_o,
    output logic [31:0]      irq_cause_o,
    output logic [N_IRQ-1:0] irq_ret_o,
    output logic             irq_busy_o
);

    localparam int IDX_W = idx_width(N_IRQ);

    irq_state_e       r_state;
    irq_state_e       w_next;
    logic [IDX_W-1:0] r_id;

    logic [N_IRQ-1:0] w_src;
    logic [N_IRQ-1:0] w_cand;
    logic             w_valid;
    logic [IDX_W-1:0] w_win_idx;
    logic             w_grant;
    logic [IDX_W-1:0] w_cause_id;

`ifdef IRQ_EDGE_DETECT_EN
    logic [N_IRQ-1:0] r_pending;
    logic [N_IRQ-1:0] r_prev;
    logic [N_IRQ-1:0] w_rise;
    logic [N_IRQ-1:0] w_grant_vec;

    assign w_rise      = irq_req_i & ~r_prev;
    assign w_grant_vec = w_grant ? (N_IRQ'(1) << w_win_idx) : '0;
    assign w_src       = r_pending;

    // A fresh edge in the grant cycle must survive the clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pending <= '0;
            r_prev    <= '0;
        end else begin
            r_prev    <= irq_req_i;
            r_pending <= (r_pending & ~w_grant_vec) | w_rise;
        end
    end
`else
    assign w_src = irq_req_i;
`endif

    assign w_cand  = w_src & irq_mask_i & {N_IRQ{mie_i}};
    assign w_grant = (r_state == IDLE) && w_valid && !exception_i;

    irq_prio_encoder #(
        .N     (N_IRQ),
        .IDX_W (IDX_W)
    ) u_enc (
        .i_vec   (w_cand),
        .o_valid (w_valid),
        .o_idx   (w_win_idx)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_id    <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_id <= w_win_idx;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (exception_i) begin
                    w_next = EXC_ACT;
                end else if (w_valid) begin
                    w_next = IRQ_ACT;
                end
            end
            IRQ_ACT: begin
                if (exception_i) begin
                    w_next = EXC_IN_IRQ;
                end else if (mret_i) begin
                    w_next = IDLE;
                end
            end
            EXC_ACT: begin
                if (mret_i) begin
                    w_next = IDLE;
                end
            end
            EXC_IN_IRQ: begin
                if (mret_i) begin
                    w_next = IRQ_ACT;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Outputs are forced to their reset values while reset is held.
    always_comb begin
        irq_o       = 1'b0;
        irq_ret_o   = '0;
        irq_busy_o  = 1'b0;
        irq_cause_o = CAUSE_BASE;
        w_cause_id  = (r_state == IDLE) ? w_win_idx : r_id;
        if (!rst_i) begin
            irq_o       = w_grant;
            irq_busy_o  = (r_state == IRQ_ACT) || (r_state == EXC_IN_IRQ);
            irq_cause_o = CAUSE_BASE + 32'(w_cause_id);
            if ((r_state == IRQ_ACT) && mret_i && !exception_i) begin
                irq_ret_o = N_IRQ'(1) << r_id;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_irq_prio_controller.sv
// ============================================================================
// Module      : tb_irq_prio_controller
// Description : Directed self-checking bench for irq_prio_controller (16 lines).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irq_prio_controller;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        exception_i;
    logic [15:0] irq_req_i;
    logic [15:0] irq_mask_i;
    logic        mie_i;
    logic        mret_i;
    logic        irq_o;
    logic [31:0] irq_cause_o;
    logic [15:0] irq_ret_o;
    logic        irq_busy_o;

    int n_total = 0;
    int n_bad   = 0;

    irq_prio_controller #(
        .N_IRQ      (16),
        .CAUSE_BASE (32'h8000_0010)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .exception_i (exception_i),
        .irq_req_i   (irq_req_i),
        .irq_mask_i  (irq_mask_i),
        .mie_i       (mie_i),
        .mret_i      (mret_i),
        .irq_o       (irq_o),
        .irq_cause_o (irq_cause_o),
        .irq_ret_o   (irq_ret_o),
        .irq_busy_o  (irq_busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge, where inputs are driven.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_i       = 1'b1;
        exception_i = 1'b0;
        irq_req_i   = '0;
        irq_mask_i  = 16'hFFFF;
        mie_i       = 1'b0;
        mret_i      = 1'b0;
        step();
        step();
        settle();
        check("rst_irq",   {31'd0, irq_o},      32'd0);
        check("rst_ret",   {16'd0, irq_ret_o},  32'd0);
        check("rst_busy",  {31'd0, irq_busy_o}, 32'd0);
        check("rst_cause", irq_cause_o,         32'h8000_0010);
        rst_i = 1'b0;
        step();

`ifdef IRQ_EDGE_DETECT_EN
        // Edge mode: first edge needs one cycle to reach pending.
        mie_i = 1'b1; irq_req_i = 16'h0020; settle();
        check("e_noirq_yet", {31'd0, irq_o}, 32'd0);
        step(); settle();
        check("e_irq",   {31'd0, irq_o}, 32'd1);
        check("e_cause", irq_cause_o,    32'h8000_0015);
        step(); mret_i = 1'b1; settle();
        check("e_busy", {31'd0, irq_busy_o}, 32'd1);
        check("e_ret",  {16'd0, irq_ret_o},  32'h0000_0020);
        step(); mret_i = 1'b0; settle();
        check("e_held_noirq1", {31'd0, irq_o}, 32'd0);
        step(); settle();
        check("e_held_noirq2", {31'd0, irq_o}, 32'd0);
        irq_req_i = '0; step();
        irq_req_i = 16'h0020; step(); settle();
        check("e_regrant",  {31'd0, irq_o}, 32'd1);
        check("e_cause2",   irq_cause_o,    32'h8000_0015);
        step(); settle();
        check("e_busy2", {31'd0, irq_busy_o}, 32'd1);
        rst_i = 1'b1; settle();
        check("e_rst_busy", {31'd0, irq_busy_o}, 32'd0);
        check("e_rst_irq",  {31'd0, irq_o},      32'd0);
        check("e_rst_cause", irq_cause_o,        32'h8000_0010);
        step(); rst_i = 1'b0; irq_req_i = '0; step();
`else
        // 1: lowest set line (3) wins, ack on mret.
        mie_i = 1'b1; irq_req_i = 16'h0028; settle();
        check("t1_irq",   {31'd0, irq_o}, 32'd1);
        check("t1_cause", irq_cause_o,    32'h8000_0013);
        step(); settle();
        check("t1_busy",   {31'd0, irq_busy_o}, 32'd1);
        check("t1_nogrant", {31'd0, irq_o},     32'd0);
        mret_i = 1'b1; settle();
        check("t1_ret", {16'd0, irq_ret_o}, 32'h0000_0008);
        step(); mret_i = 1'b0; irq_req_i = '0; settle();
        check("t1_ret_off", {16'd0, irq_ret_o},  32'd0);
        check("t1_idle",    {31'd0, irq_busy_o}, 32'd0);

        // 2: masked line and global disable.
        irq_mask_i = 16'hFFF7; irq_req_i = 16'h0008; settle();
        check("t2_masked", {31'd0, irq_o}, 32'd0);
        check("t2_cause",  irq_cause_o,    32'h8000_0010);
        irq_mask_i = 16'hFFFF; mie_i = 1'b0; irq_req_i = 16'hFFFF; settle();
        check("t2_mie0", {31'd0, irq_o}, 32'd0);
        step(); settle();
        check("t2_busy", {31'd0, irq_busy_o}, 32'd0);

        // 3: exception nested inside line 2 service.
        mie_i = 1'b1; irq_req_i = 16'h0004; settle();
        check("t3_irq", {31'd0, irq_o}, 32'd1);
        step(); exception_i = 1'b1; settle();
        check("t3_noregrant", {31'd0, irq_o}, 32'd0);
        step(); exception_i = 1'b0; settle();
        check("t3_exc_busy",  {31'd0, irq_busy_o}, 32'd1);
        check("t3_exc_cause", irq_cause_o,         32'h8000_0012);
        mret_i = 1'b1; settle();
        check("t3_noack", {16'd0, irq_ret_o}, 32'd0);
        step(); mret_i = 1'b0; settle();
        check("t3_back_busy", {31'd0, irq_busy_o}, 32'd1);
        mret_i = 1'b1; irq_req_i = '0; settle();
        check("t3_ret", {16'd0, irq_ret_o}, 32'h0000_0004);
        step(); mret_i = 1'b0; settle();
        check("t3_idle", {31'd0, irq_busy_o}, 32'd0);

        // 4: exception beats simultaneous request.
        exception_i = 1'b1; irq_req_i = 16'h0001; settle();
        check("t4_noirq", {31'd0, irq_o}, 32'd0);
        step(); exception_i = 1'b0; settle();
        check("t4_exc_busy",  {31'd0, irq_busy_o}, 32'd0);
        check("t4_exc_noirq", {31'd0, irq_o},      32'd0);
        check("t4_exc_cause", irq_cause_o,         32'h8000_0012);
        mret_i = 1'b1; settle();
        check("t4_noack", {16'd0, irq_ret_o}, 32'd0);
        step(); mret_i = 1'b0; settle();
        check("t4_irq",   {31'd0, irq_o}, 32'd1);
        check("t4_cause", irq_cause_o,    32'h8000_0010);
        step();

        // 5: mret with exception in IRQ_ACT -> no ack, EXC_IN_IRQ.
        mret_i = 1'b1; exception_i = 1'b1; settle();
        check("t5_noack", {16'd0, irq_ret_o}, 32'd0);
        step(); exception_i = 1'b0; settle();
        check("t5_busy",    {31'd0, irq_busy_o}, 32'd1);
        check("t5_exc_noack", {16'd0, irq_ret_o}, 32'd0);
        step(); mret_i = 1'b0; settle();
        check("t5_irqact", {31'd0, irq_busy_o}, 32'd1);

        // Async reset during IRQ_ACT.
        rst_i = 1'b1; mret_i = 1'b1; settle();
        check("rst_mid_busy", {31'd0, irq_busy_o}, 32'd0);
        check("rst_mid_irq",  {31'd0, irq_o},      32'd0);
        check("rst_mid_ret",  {16'd0, irq_ret_o},  32'd0);
        step(); mret_i = 1'b0; irq_req_i = '0; rst_i = 1'b0; settle();
        check("post_rst_cause", irq_cause_o, 32'h8000_0010);
        step();
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
